// File: rtl/string_table_pkg.sv
// Shared string-table types: handle type, null handle, per-request delta type
// and the width rule for summed reference-count deltas.
package string_table_pkg;

  typedef logic [63:0]        string_handle_t;
  typedef logic signed [7:0]  refcount_delta_t;

  localparam string_handle_t NULL_HANDLE = '0;

  // Wide enough that adding num_req deltas of delta_width bits cannot overflow.
  function automatic int sum_width(input int delta_width, input int num_req);
    return delta_width + $clog2(num_req) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin pick: the first valid requester at or after ptr, wrapping modulo N.
// Returns the winner as a one-hot vector and as a binary index.
module rr_arbiter_onehot #(
  parameter int N         = 4,
  localparam int IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         valid,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 any,
  output logic [N-1:0]         grant,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  localparam logic [IDX_WIDTH:0] N_EXT = (IDX_WIDTH + 1)'(N);

  logic [2*N-1:0]       doubled;
  logic [N-1:0]         rotated;
  logic [IDX_WIDTH-1:0] offset;
  logic [IDX_WIDTH:0]   raw_idx;

  // Rotating the request vector so ptr lands at bit 0 turns round-robin into
  // a plain lowest-bit priority search.
  assign doubled = {valid, valid} >> ptr;
  assign rotated = doubled[N-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    offset = '0;
    any    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = k[IDX_WIDTH-1:0];
        any    = 1'b1;
      end
    end
  end

  always_comb begin
    raw_idx   = {1'b0, ptr} + {1'b0, offset};
    if (raw_idx >= N_EXT) raw_idx = raw_idx - N_EXT;
    grant_idx = raw_idx[IDX_WIDTH-1:0];
    grant     = '0;
    grant[grant_idx] = any;
  end

endmodule

// File: rtl/string_refcount_scheduler.sv
// Shares the string table's single refcount update port among NUM_REQ requesters:
// round-robin arbitration, same-handle coalescing, zero-sum elision, statistics.
module string_refcount_scheduler
  import string_table_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HANDLE_WIDTH = 64,
  parameter int DELTA_WIDTH  = 8,
  parameter int COUNT_WIDTH  = 16,
  localparam int SUM_WIDTH   = sum_width(DELTA_WIDTH, NUM_REQ),
  localparam int IDX_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*HANDLE_WIDTH-1:0] req_handle,
  input  logic [NUM_REQ*DELTA_WIDTH-1:0]  req_delta,
  output logic                            upd_valid,
  input  logic                            upd_ready,
  output logic [HANDLE_WIDTH-1:0]         upd_handle,
  output logic [SUM_WIDTH-1:0]            upd_delta,
  output logic [COUNT_WIDTH-1:0]          issued_count,
  output logic [COUNT_WIDTH-1:0]          elided_count,
  output logic                            null_err
);

  logic [HANDLE_WIDTH-1:0]       handles [NUM_REQ];
  logic signed [DELTA_WIDTH-1:0] deltas  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign handles[i] = req_handle[i*HANDLE_WIDTH +: HANDLE_WIDTH];
    assign deltas[i]  = req_delta[i*DELTA_WIDTH +: DELTA_WIDTH];
  end

  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] ptr_next;
  logic                 any_valid;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [IDX_WIDTH-1:0] win_idx;

  rr_arbiter_onehot #(.N(NUM_REQ)) u_arb (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .any       (any_valid),
    .grant     (win_onehot),
    .grant_idx (win_idx)
  );

  logic                        can_load;
  logic                        grant_active;
  logic [HANDLE_WIDTH-1:0]     win_handle;
  logic [NUM_REQ-1:0]          grant_set;
  logic signed [SUM_WIDTH-1:0] sum;
  logic                        null_grant;
  logic                        zero_grant;
  logic                        load_upd;
  logic                        upd_xfer;

  assign can_load     = !upd_valid || upd_ready;
  assign grant_active = rst_n && can_load && any_valid;
  assign win_handle   = handles[win_idx];

  // The winner is always in its own grant set; others join on an equal handle.
  always_comb begin
    grant_set = '0;
    sum       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (handles[i] == win_handle)) begin
        grant_set[i] = 1'b1;
        sum          = sum + SUM_WIDTH'(deltas[i]);
      end
    end
  end

  assign req_ready  = grant_active ? grant_set : '0;
  assign null_grant = grant_active && (win_handle == HANDLE_WIDTH'(NULL_HANDLE));
  assign zero_grant = grant_active && !null_grant && (sum == '0);
  assign load_upd   = grant_active && !null_grant && (sum != '0);
  assign upd_xfer   = upd_valid && upd_ready;
  assign ptr_next   = (win_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + IDX_WIDTH'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid    <= 1'b0;
      upd_handle   <= '0;
      upd_delta    <= '0;
      issued_count <= '0;
      elided_count <= '0;
      null_err     <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      if (can_load) upd_valid <= load_upd;
      if (load_upd) begin
        upd_handle <= win_handle;
        upd_delta  <= sum;
      end
      if (upd_xfer && (issued_count != '1)) issued_count <= issued_count + COUNT_WIDTH'(1);
      if (zero_grant && (elided_count != '1)) elided_count <= elided_count + COUNT_WIDTH'(1);
      if (null_grant) null_err <= 1'b1;
      if (grant_active) rr_ptr <= ptr_next;
    end
  end

  logic unused_onehot;
  assign unused_onehot = ^win_onehot;

endmodule
